evict_write_buffer: RTL and testbench

EVICT_WRITE_BUFFER -- requirements
Module: evict_write_buffer

---
 rtl/lc3b_types.sv | 23 ++
 rtl/ewb_control.sv | 109 ++++++++++
 rtl/evict_write_buffer.sv | 94 +++++++++
 tb/tb_evict_write_buffer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b widths and the evict write buffer state encoding.
package lc3b_types;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned LINE_W  = 128;
  localparam int unsigned TAG_LSB = 4;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] l1_cache_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PMEM = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } ewb_state_t;

  // Two addresses fall in the same cache line when bits [15:4] agree.
  function automatic logic tag_eq(input lc3b_word a, input lc3b_word b);
    return a[WORD_W-1:TAG_LSB] == b[WORD_W-1:TAG_LSB];
  endfunction

endpackage

// File: rtl/ewb_control.sv
// Sequencing FSM for the evict write buffer; datapath strobes are _c outputs.
// Build option EWB_READ_HIT_EN: serve line-matching reads from the buffer.
module ewb_control
  import lc3b_types::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_read,
  input  logic i_write,
  input  logic i_valid,
  input  logic i_hit,
  input  logic i_pmem_resp,
  output logic o_pmem_read,
  output logic o_pmem_write,
  output logic o_resp,
  output logic o_capture_c,
  output logic o_rdata_ld_c,
  output logic o_clear_c,
  output logic o_rd_addr_ld_c,
  output logic o_drain_ld_c
);

  ewb_state_t r_state;
  ewb_state_t w_next;
  logic       w_resp;
  logic       r_pmem_read;
  logic       r_pmem_write;
  logic       r_resp;

  // State and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_resp       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_pmem_read  <= (w_next == RD_PMEM);
      r_pmem_write <= (w_next == DRAIN);
      r_resp       <= w_resp;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_resp         = 1'b0;
    o_capture_c    = 1'b0;
    o_rdata_ld_c   = 1'b0;
    o_clear_c      = 1'b0;
    o_rd_addr_ld_c = 1'b0;
    o_drain_ld_c   = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Reads win over simultaneous writes; the write is dropped.
        if (i_read) begin
          if (i_hit) begin
`ifdef EWB_READ_HIT_EN
            o_rdata_ld_c = 1'b1;
            w_resp       = 1'b1;
            w_next       = DONE;
`else
            o_drain_ld_c = 1'b1;
            w_next       = DRAIN;
`endif
          end else begin
            o_rd_addr_ld_c = 1'b1;
            w_next         = RD_PMEM;
          end
        end else if (i_write) begin
          if (i_valid) begin
            o_drain_ld_c = 1'b1;
            w_next       = DRAIN;
          end else begin
            o_capture_c = 1'b1;
            w_resp      = 1'b1;
            w_next      = DONE;
          end
        end else if (i_valid) begin
          o_drain_ld_c = 1'b1;
          w_next       = DRAIN;
        end
      end
      RD_PMEM: begin
        if (i_pmem_resp) begin
          o_rdata_ld_c = 1'b1;
          w_resp       = 1'b1;
          w_next       = DONE;
        end
      end
      DRAIN: begin
        if (i_pmem_resp) begin
          o_clear_c = 1'b1;
          w_next    = IDLE;
        end
      end
      DONE: begin
        // Wait out the arbiter's late request drop before accepting again.
        if (!i_read && !i_write) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_pmem_read  = r_pmem_read;
  assign o_pmem_write = r_pmem_write;
  assign o_resp       = r_resp;

endmodule

// File: rtl/evict_write_buffer.sv
// Single-entry evict write buffer between L1 writebacks and physical memory.
// Build option EWB_READ_HIT_EN: forward buffered line on a read tag hit.
module evict_write_buffer
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_read,
  input  logic         in_write,
  input  lc3b_word     in_address,
  input  l1_cache_line in_wdata,
  output logic         out_resp,
  output l1_cache_line out_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output lc3b_word     pmem_address,
  output l1_cache_line pmem_wdata,
  input  l1_cache_line pmem_rdata,
  input  logic         pmem_resp
);

  logic         r_valid;
  lc3b_word     r_addr;
  l1_cache_line r_line;
  l1_cache_line r_rdata;
  lc3b_word     r_pmem_address;
  l1_cache_line r_pmem_wdata;

  logic         w_hit;
  logic         w_capture;
  logic         w_rdata_ld;
  logic         w_clear;
  logic         w_rd_addr_ld;
  logic         w_drain_ld;
  l1_cache_line w_rdata_src;

  assign w_hit = r_valid && tag_eq(r_addr, in_address);

`ifdef EWB_READ_HIT_EN
  assign w_rdata_src = pmem_read ? pmem_rdata : r_line;
`else
  assign w_rdata_src = pmem_rdata;
`endif

  ewb_control u_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_read         (in_read),
    .i_write        (in_write),
    .i_valid        (r_valid),
    .i_hit          (w_hit),
    .i_pmem_resp    (pmem_resp),
    .o_pmem_read    (pmem_read),
    .o_pmem_write   (pmem_write),
    .o_resp         (out_resp),
    .o_capture_c    (w_capture),
    .o_rdata_ld_c   (w_rdata_ld),
    .o_clear_c      (w_clear),
    .o_rd_addr_ld_c (w_rd_addr_ld),
    .o_drain_ld_c   (w_drain_ld)
  );

  // Buffer entry, upstream read data and downstream request registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid        <= 1'b0;
      r_addr         <= '0;
      r_line         <= '0;
      r_rdata        <= '0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      if (w_capture) begin
        r_valid <= 1'b1;
        r_addr  <= in_address;
        r_line  <= in_wdata;
      end else if (w_clear) begin
        r_valid <= 1'b0;
      end
      if (w_rdata_ld) r_rdata <= w_rdata_src;
      if (w_rd_addr_ld) begin
        r_pmem_address <= in_address;
      end else if (w_drain_ld) begin
        r_pmem_address <= r_addr;
        r_pmem_wdata   <= r_line;
      end
    end
  end

  assign out_rdata    = r_rdata;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_evict_write_buffer.sv
// Directed bench for evict_write_buffer with a fixed-latency pmem responder.
module tb_evict_write_buffer;

  localparam int unsigned LAT = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_read, in_write;
  logic [15:0]  in_address;
  logic [127:0] in_wdata;
  logic         out_resp;
  logic [127:0] out_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_vec  = 0;
  int n_miss = 0;

  logic         log_we[$];
  logic [15:0]  log_addr[$];
  logic [127:0] log_data[$];
  int           pm_cnt = 0;
  logic         prev_resp = 1'b0;
  logic         viol_excl = 1'b0;
  logic         viol_resp = 1'b0;

  localparam logic [127:0] LINE_A = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] LINE_B = 128'hbbbb_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] LINE_C = 128'hcccc_cccc_0000_0000_cccc_cccc_0000_0001;
  localparam logic [127:0] LINE_D = 128'hdddd_1234_dddd_5678_dddd_9abc_dddd_def0;

  evict_write_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_read      (in_read),
    .in_write     (in_write),
    .in_address   (in_address),
    .in_wdata     (in_wdata),
    .out_resp     (out_resp),
    .out_rdata    (out_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pline(input logic [15:0] a);
    logic [15:0] k;
    k = a ^ 16'hA5A5;
    return {8{k}};
  endfunction

  // pmem model: responds LAT negedges after a request appears, logs each op.
  always @(negedge clk) begin
    if (!rst_n) begin
      pmem_resp = 1'b0;
      pm_cnt    = 0;
    end else if (pmem_resp) begin
      pmem_resp = 1'b0;
      pm_cnt    = 0;
    end else if (pmem_read || pmem_write) begin
      pm_cnt = pm_cnt + 1;
      if (pm_cnt == LAT) begin
        pmem_resp  = 1'b1;
        pmem_rdata = pline(pmem_address);
        log_we.push_back(pmem_write);
        log_addr.push_back(pmem_address);
        log_data.push_back(pmem_write ? pmem_wdata : 128'h0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (pmem_read && pmem_write) viol_excl = 1'b1;
      if (out_resp && prev_resp) viol_resp = 1'b1;
    end
    prev_resp = out_resp;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one upstream request at a negedge; returns one negedge after dropping it.
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [127:0] d, input int hold,
                        output int lat, output logic [127:0] rdat, output int pulses);
    lat = -1; rdat = '0; pulses = 0;
    in_read = rd; in_write = wr; in_address = a; in_wdata = d;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (out_resp) begin
        lat = n; rdat = out_rdata; pulses = 1;
        break;
      end
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_resp) pulses = pulses + 1;
    end
    in_read = 1'b0; in_write = 1'b0;
    @(negedge clk);
    if (out_resp) pulses = pulses + 1;
  endtask

  task automatic wait_pmem_write(output logic seen);
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (pmem_write) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_log();
    log_we.delete(); log_addr.delete(); log_data.delete();
  endtask

  task automatic settle();
    repeat (20) @(negedge clk);
    clear_log();
  endtask

  initial begin
    int           lat, pulses;
    logic [127:0] rd;
    logic         seen;
    rst_n = 1'b0; in_read = 1'b0; in_write = 1'b0;
    in_address = '0; in_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_resp",  128'(out_resp), 128'(0));
    check("rst_pmem_rw",   128'({pmem_read, pmem_write}), 128'(0));
    check("rst_pmem_addr", 128'(pmem_address), 128'(0));
    check("rst_valid",     128'(dut.r_valid), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Buffered write then background drain.
    do_req(1'b0, 1'b1, 16'h1230, LINE_A, 0, lat, rd, pulses);
    check("wr_lat",         128'(lat), 128'(1));
    check("wr_no_pmem",     128'(log_we.size()), 128'(0));
    check("wr_valid",       128'(dut.r_valid), 128'(1));
    for (int n = 0; n < 20 && log_we.size() == 0; n++) @(negedge clk);
    check("drain_cnt",  128'(log_we.size()), 128'(1));
    if (log_we.size() > 0) begin
      check("drain_we",   128'(log_we[0]), 128'(1));
      check("drain_addr", 128'(log_addr[0]), 128'h1230);
      check("drain_data", log_data[0], LINE_A);
    end
    repeat (3) @(negedge clk);
    check("drain_valid", 128'(dut.r_valid), 128'(0));
    settle();

    // Read that matches the buffered line.
    do_req(1'b0, 1'b1, 16'h1230, LINE_A, 0, lat, rd, pulses);
    do_req(1'b1, 1'b0, 16'h1238, '0, 0, lat, rd, pulses);
`ifdef EWB_READ_HIT_EN
    check("hit_lat",   128'(lat), 128'(1));
    check("hit_rdata", rd, LINE_A);
    check("hit_pmem",  128'(log_we.size()), 128'(0));
`else
    check("hitd_lat",   128'(lat), 128'(8));
    check("hitd_rdata", rd, pline(16'h1238));
    check("hitd_cnt",   128'(log_we.size()), 128'(2));
    if (log_we.size() >= 2) begin
      check("hitd_op0", {log_we[0], log_addr[0]}, {1'b1, 16'h1230});
      check("hitd_op1", {log_we[1], log_addr[1]}, {1'b0, 16'h1238});
    end
`endif
    settle();

    // Read miss bypasses the pending write.
    do_req(1'b0, 1'b1, 16'h1230, LINE_A, 0, lat, rd, pulses);
    do_req(1'b1, 1'b0, 16'h4000, '0, 0, lat, rd, pulses);
    check("miss_lat",   128'(lat), 128'(4));
    check("miss_rdata", rd, pline(16'h4000));
    if (log_we.size() > 0)
      check("miss_op0", {log_we[0], log_addr[0]}, {1'b0, 16'h4000});
    check("miss_valid", {dut.r_valid, dut.r_addr}, {1'b1, 16'h1230});
    settle();

    // Write arriving while the buffer is draining.
    do_req(1'b0, 1'b1, 16'h1230, LINE_A, 0, lat, rd, pulses);
    wait_pmem_write(seen);
    check("busy_seen", 128'(seen), 128'(1));
    do_req(1'b0, 1'b1, 16'h5550, LINE_B, 0, lat, rd, pulses);
    check("busy_lat",  128'(lat), 128'(4));
    check("busy_cnt",  128'(log_we.size()), 128'(1));
    if (log_we.size() > 0)
      check("busy_op0", {log_we[0], log_addr[0], log_data[0]}, {1'b1, 16'h1230, LINE_A});
    check("busy_entry", {dut.r_valid, dut.r_addr, dut.r_line}, {1'b1, 16'h5550, LINE_B});
    settle();

    // Request held past the response.
    do_req(1'b0, 1'b1, 16'h2220, LINE_C, 3, lat, rd, pulses);
    repeat (3) begin
      @(negedge clk);
      if (out_resp) pulses = pulses + 1;
    end
    check("hold_pulses", 128'(pulses), 128'(1));
    settle();

    // Simultaneous read and write: read only.
    do_req(1'b1, 1'b1, 16'h6000, LINE_B, 0, lat, rd, pulses);
    check("both_lat",   128'(lat), 128'(4));
    check("both_rdata", rd, pline(16'h6000));
    check("both_valid", 128'(dut.r_valid), 128'(0));
    settle();

    // Reset in the middle of a drain.
    do_req(1'b0, 1'b1, 16'h7770, LINE_D, 0, lat, rd, pulses);
    wait_pmem_write(seen);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstd_pmem_write", 128'(pmem_write), 128'(0));
    check("rstd_out_resp",   128'(out_resp), 128'(0));
    check("rstd_valid",      128'(dut.r_valid), 128'(0));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rstd_no_op", 128'(log_we.size()), 128'(0));

    check("rw_exclusive",   128'(viol_excl), 128'(0));
    check("resp_single_cy", 128'(viol_resp), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
